// File: rtl/wb_mailbox_device.sv
// Wishbone classic responder bridging bus writes/reads to a local core through TX and RX FIFOs.
// Define WB_MBOX_RTY_EN to terminate full/empty accesses with rty_o; otherwise they stall in WAIT.
module wb_mailbox_device #(
  parameter int DAT_WIDTH   = 8,
  parameter int DEPTH       = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cyc_i,
  input  logic                         stb_i,
  input  logic                         we_i,
  input  logic [DAT_WIDTH-1:0]         dat_i,
  output logic                         ack_o,
  output logic                         err_o,
  output logic                         rty_o,
  output logic [DAT_WIDTH-1:0]         dat_o,
  output logic [DAT_WIDTH-1:0]         tx_data_o,
  output logic                         tx_valid_o,
  input  logic                         tx_ready_i,
  input  logic [DAT_WIDTH-1:0]         rx_data_i,
  input  logic                         rx_valid_i,
  output logic                         rx_ready_o,
  output logic [$clog2(DEPTH+1)-1:0]   tx_level_o,
  output logic [$clog2(DEPTH+1)-1:0]   rx_level_o
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic [DAT_WIDTH-1:0]  dat_q, dat_d;
  logic                  request, decide, can_act;

  logic [DAT_WIDTH-1:0]  tx_mem [DEPTH];
  logic [DAT_WIDTH-1:0]  rx_mem [DEPTH];
  logic [PW-1:0]         tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [LW-1:0]         tx_level_q, rx_level_q;
  logic                  tx_push, tx_pop, rx_push, rx_pop;
  logic                  tx_full, rx_empty;

`ifdef WB_MBOX_RTY_EN
  logic                  rty_q, rty_d;
`endif

  assign request  = cyc_i && stb_i;
  assign tx_full  = (tx_level_q == LW'(DEPTH));
  assign rx_empty = (rx_level_q == '0);
  assign tx_pop   = tx_ready_i && tx_valid_o;
  assign rx_push  = rx_valid_i && rx_ready_o;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    dat_d   = '0;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    decide  = 1'b0;
    can_act = 1'b0;
`ifdef WB_MBOX_RTY_EN
    rty_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (request) begin
          if (WAIT_STATES == 0) begin
            decide = 1'b1;
          end else begin
            cnt_d   = CW'(WAIT_STATES - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!request)            state_d = S_IDLE;
        else if (cnt_q != '0)    cnt_d   = cnt_q - CW'(1);
        else                     decide  = 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Full/empty come from pre-edge occupancy, so same-edge local traffic cannot flip a decision.
    if (decide) begin
      can_act = we_i ? !tx_full : !rx_empty;
      if (can_act) begin
        ack_d   = 1'b1;
        state_d = S_RESP;
        if (we_i) begin
          tx_push = 1'b1;
        end else begin
          rx_pop = 1'b1;
          dat_d  = rx_mem[rx_rd_q];
        end
      end else begin
`ifdef WB_MBOX_RTY_EN
        rty_d   = 1'b1;
        state_d = S_RESP;
`else
        cnt_d   = '0;
        state_d = S_WAIT;
`endif
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

`ifdef WB_MBOX_RTY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rty_q <= 1'b0;
    else         rty_q <= rty_d;
  end
  assign rty_o = rty_q;
`else
  assign rty_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_level_q <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_level_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + PW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + PW'(1);
      if (rx_push) rx_wr_q <= rx_wr_q + PW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_level_q <= tx_level_q + LW'(1);
        2'b01:   tx_level_q <= tx_level_q - LW'(1);
        default: tx_level_q <= tx_level_q;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_level_q <= rx_level_q + LW'(1);
        2'b01:   rx_level_q <= rx_level_q - LW'(1);
        default: rx_level_q <= rx_level_q;
      endcase
    end
  end

  // NOTE: storage is not reset; emptiness is carried entirely by the pointers and levels.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_q] <= dat_i;
    if (rx_push) rx_mem[rx_wr_q] <= rx_data_i;
  end

  assign ack_o      = ack_q;
  assign err_o      = 1'b0;
  assign dat_o      = dat_q;
  assign tx_data_o  = tx_mem[tx_rd_q];
  assign tx_valid_o = (tx_level_q != '0);
  assign rx_ready_o = (rx_level_q != LW'(DEPTH));
  assign tx_level_o = tx_level_q;
  assign rx_level_o = rx_level_q;

endmodule
